// File: rtl/div_pkg.sv
// div_pkg: shared constants and state encoding for the sequential divider.
package div_pkg;

  // Default widths: dividend/quotient, divisor/remainder, external adder.
  localparam int DIV_A_W = 16;
  localparam int DIV_B_W = 8;
  localparam int DIV_S_W = 16;

  // Bit counter width for the A_W iteration steps.
  localparam int DIV_CNT_W = $clog2(DIV_A_W);

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_NEG  = 2'd1,
    ST_ITER = 2'd2
  } div_state_e;

  // Plain-vector copies of the state codes for the state register.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_NEG  = 2'd1;
  localparam logic [1:0] S_ITER = 2'd2;

endpackage

// File: rtl/div_if.sv
// div_if: start/busy handshake, operands, results and the three-wire
// connection to the shared external adder.
interface div_if #(
  parameter int A_W = div_pkg::DIV_A_W,
  parameter int B_W = div_pkg::DIV_B_W,
  parameter int S_W = div_pkg::DIV_S_W
);
  import div_pkg::*;

  logic           start;
  logic [A_W-1:0] a_i;
  logic [B_W-1:0] b_i;
  logic [A_W-1:0] result;
  logic [B_W-1:0] remainder;
  logic           busy;
  logic           div_by_zero;
  logic [S_W-1:0] sum_in_a;
  logic [S_W-1:0] sum_in_b;
  logic [S_W-1:0] sum_out;

  // Requester side.
  modport master (
    output start, a_i, b_i,
    input  result, remainder, busy, div_by_zero
  );

  // Divider side: takes the request and drives the shared adder.
  modport slave (
    input  start, a_i, b_i, sum_out,
    output result, remainder, busy, div_by_zero, sum_in_a, sum_in_b
  );

  // Shared adder side.
  modport adder (
    input  sum_in_a, sum_in_b,
    output sum_out
  );

endinterface

// File: rtl/sum.sv
// sum: the shared combinational adder, y = (a + b) mod 2^W.
module sum #(
  parameter int W = 16
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] y_o
);

  assign y_o = a_i + b_i;

endmodule

// File: rtl/div.sv
// div: sequential restoring divider, A_W-bit dividend by B_W-bit divisor.
// All additions/subtractions go through the external shared adder; the
// trial-subtraction outcome is read from the adder's sign bit only.
// Optional build macro DIV_ZERO_FAST_EN: a zero divisor finishes in one
// cycle without touching the adder, with the same final outputs.
module div
  import div_pkg::*;
#(
  parameter int A_W = DIV_A_W,
  parameter int B_W = DIV_B_W,
  parameter int S_W = DIV_S_W
) (
  input logic clk,
  input logic rst,
  div_if.slave bus
);

  localparam int CNT_W = $clog2(A_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(A_W - 1);

  logic [1:0]       state_q, state_d;
  logic [A_W-1:0]   dq_q, dq_d;            // dividend shifting out, quotient shifting in
  logic [B_W-1:0]   divisor_q, divisor_d;
  logic [S_W-1:0]   nb_q, nb_d;            // negated divisor
  logic [B_W:0]     rem_q, rem_d;          // partial remainder R
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [A_W-1:0]   result_q, result_d;
  logic [B_W-1:0]   remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
`ifdef DIV_ZERO_FAST_EN
  logic             zf_q, zf_d;            // zero divisor seen at start
`endif

  logic [S_W-1:0]   sum_a, sum_b;
  logic [B_W:0]     trial;
  logic             qbit;

  // Next-state logic for the controller and datapath, plus adder operands.
  always_comb begin
    state_d     = state_q;
    dq_d        = dq_q;
    divisor_d   = divisor_q;
    nb_d        = nb_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    result_d    = result_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
`ifdef DIV_ZERO_FAST_EN
    zf_d        = zf_q;
`endif
    sum_a       = '0;
    sum_b       = '0;
    trial       = {rem_q[B_W-1:0], dq_q[A_W-1]};
    qbit        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          dq_d      = bus.a_i;
          divisor_d = bus.b_i;
          rem_d     = '0;
          cnt_d     = '0;
          busy_d    = 1'b1;
          state_d   = S_NEG;
`ifdef DIV_ZERO_FAST_EN
          zf_d      = ~|bus.b_i;
`endif
        end
      end

      S_NEG: begin
`ifdef DIV_ZERO_FAST_EN
        if (zf_q) begin
          // Zero divisor: report the same outputs the full path would give.
          result_d    = '1;
          remainder_d = dq_q[B_W-1:0];
          dbz_d       = 1'b1;
          busy_d      = 1'b0;
          zf_d        = 1'b0;
          state_d     = S_IDLE;
        end else begin
          sum_a   = ~{{(S_W-B_W){1'b0}}, divisor_q};
          sum_b   = S_W'(1);
          nb_d    = bus.sum_out;
          state_d = S_ITER;
        end
`else
        // Two's-complement negation of the divisor on the shared adder.
        sum_a   = ~{{(S_W-B_W){1'b0}}, divisor_q};
        sum_b   = S_W'(1);
        nb_d    = bus.sum_out;
        state_d = S_ITER;
`endif
      end

      S_ITER: begin
        // Trial subtract T - divisor; a clear sign bit means T >= divisor.
        sum_a = {{(S_W-B_W-1){1'b0}}, trial};
        sum_b = nb_q;
        qbit  = ~bus.sum_out[S_W-1];
        rem_d = qbit ? bus.sum_out[B_W:0] : trial;
        dq_d  = {dq_q[A_W-2:0], qbit};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          result_d    = {dq_q[A_W-2:0], qbit};
          remainder_d = rem_d[B_W-1:0];
          dbz_d       = ~|divisor_q;
          busy_d      = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any division in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      dq_q        <= '0;
      divisor_q   <= '0;
      nb_q        <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      result_q    <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
`ifdef DIV_ZERO_FAST_EN
      zf_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      dq_q        <= dq_d;
      divisor_q   <= divisor_d;
      nb_q        <= nb_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      result_q    <= result_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
`ifdef DIV_ZERO_FAST_EN
      zf_q        <= zf_d;
`endif
    end
  end

  assign bus.result      = result_q;
  assign bus.remainder   = remainder_q;
  assign bus.busy        = busy_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.sum_in_a    = sum_a;
  assign bus.sum_in_b    = sum_b;

endmodule

// File: tb/tb_div.sv
// tb_div: randomized and directed checks of div against an arithmetic model.
module tb_div;
  import div_pkg::*;

`ifdef DIV_ZERO_FAST_EN
  localparam int ZERO_BUSY = 1;
`else
  localparam int ZERO_BUSY = DIV_A_W + 1;
`endif
  localparam int FULL_BUSY = DIV_A_W + 1;
  localparam int MAX_WAIT  = 200;

  logic clk = 1'b0;
  logic rst = 1'b0;

  div_if #(.A_W(DIV_A_W), .B_W(DIV_B_W), .S_W(DIV_S_W)) dif ();

  div #(.A_W(DIV_A_W), .B_W(DIV_B_W), .S_W(DIV_S_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif.slave)
  );

  sum #(.W(DIV_S_W)) u_sum (
    .a_i (dif.sum_in_a),
    .b_i (dif.sum_in_b),
    .y_o (dif.sum_out)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference: integer division; zero divisor gives all-ones and low dividend byte.
  function automatic void model(input int a, input int b,
                                output int q, output int r, output int z);
    if (b == 0) begin
      q = 16'hFFFF;
      r = a & 8'hFF;
      z = 1;
    end else begin
      q = a / b;
      r = a % b;
      z = 0;
    end
  endfunction

  // Issue one division and count cycles until busy falls (bounded).
  task automatic run_div(input logic [15:0] a, input logic [7:0] b, output int cycles);
    @(negedge clk);
    dif.start = 1'b1;
    dif.a_i   = a;
    dif.b_i   = b;
    @(posedge clk);
    #1;
    dif.start = 1'b0;
    cycles = 0;
    while (dif.busy === 1'b1 && cycles < MAX_WAIT) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (dif.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b want=0", dif.busy); end
    vectors++; if (dif.result !== 16'h0) begin miscompares++; $display("FAIL reset_result got=%h want=0000", dif.result); end
    vectors++; if (dif.remainder !== 8'h0) begin miscompares++; $display("FAIL reset_remainder got=%h want=00", dif.remainder); end
    vectors++; if (dif.div_by_zero !== 1'b0) begin miscompares++; $display("FAIL reset_dbz got=%b want=0", dif.div_by_zero); end
    vectors++; if (dif.sum_in_a !== 16'h0) begin miscompares++; $display("FAIL reset_sum_in_a got=%h want=0000", dif.sum_in_a); end
    vectors++; if (dif.sum_in_b !== 16'h0) begin miscompares++; $display("FAIL reset_sum_in_b got=%h want=0000", dif.sum_in_b); end
    $display("reset: busy=%b result=%h remainder=%h dbz=%b", dif.busy, dif.result, dif.remainder, dif.div_by_zero);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_directed();
    int ta[5] = '{6, 1000, 65535, 5, 1234};
    int tb[5] = '{2, 7, 255, 9, 0};
    int q, r, z, cyc, want_cyc;
    for (int i = 0; i < 5; i++) begin
      model(ta[i], tb[i], q, r, z);
      want_cyc = (tb[i] == 0) ? ZERO_BUSY : FULL_BUSY;
      run_div(16'(ta[i]), 8'(tb[i]), cyc);
      $display("directed %0d / %0d -> q=%0d r=%0d dbz=%b busy=%0d", ta[i], tb[i], dif.result, dif.remainder, dif.div_by_zero, cyc);
      vectors++; if (dif.result !== 16'(q)) begin miscompares++; $display("FAIL dir_result %0d/%0d got=%0d want=%0d", ta[i], tb[i], dif.result, q); end
      vectors++; if (dif.remainder !== 8'(r)) begin miscompares++; $display("FAIL dir_remainder %0d/%0d got=%0d want=%0d", ta[i], tb[i], dif.remainder, r); end
      vectors++; if (dif.div_by_zero !== 1'(z)) begin miscompares++; $display("FAIL dir_dbz %0d/%0d got=%b want=%0d", ta[i], tb[i], dif.div_by_zero, z); end
      vectors++; if (cyc != want_cyc) begin miscompares++; $display("FAIL dir_busy_cycles %0d/%0d got=%0d want=%0d", ta[i], tb[i], cyc, want_cyc); end
    end
  endtask

  // Outputs must hold their previous values while a division runs.
  task automatic test_hold();
    logic [15:0] prev_q;
    logic [7:0]  prev_r;
    int cyc;
    prev_q = dif.result;
    prev_r = dif.remainder;
    @(negedge clk);
    dif.start = 1'b1; dif.a_i = 16'd6; dif.b_i = 8'd2;
    @(posedge clk);
    #1;
    dif.start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    vectors++; if (dif.result !== prev_q) begin miscompares++; $display("FAIL hold_result got=%h want=%h", dif.result, prev_q); end
    vectors++; if (dif.remainder !== prev_r) begin miscompares++; $display("FAIL hold_remainder got=%h want=%h", dif.remainder, prev_r); end
    cyc = 0;
    while (dif.busy === 1'b1 && cyc < MAX_WAIT) begin @(posedge clk); #1; cyc++; end
    vectors++; if (dif.result !== 16'd3) begin miscompares++; $display("FAIL hold_final got=%0d want=3", dif.result); end
    vectors++; if (dif.sum_in_a !== 16'h0 || dif.sum_in_b !== 16'h0) begin miscompares++; $display("FAIL idle_adder got=%h/%h want=0000/0000", dif.sum_in_a, dif.sum_in_b); end
    $display("hold: 6 / 2 -> q=%0d r=%0d", dif.result, dif.remainder);
  endtask

  task automatic test_start_ignored();
    int cyc;
    @(negedge clk);
    dif.start = 1'b1; dif.a_i = 16'd1000; dif.b_i = 8'd7;
    @(posedge clk);
    #1;
    dif.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    dif.start = 1'b1; dif.a_i = 16'd50; dif.b_i = 8'd5;
    @(posedge clk);
    #1;
    dif.start = 1'b0;
    cyc = 5;
    while (dif.busy === 1'b1 && cyc < MAX_WAIT) begin @(posedge clk); #1; cyc++; end
    $display("start_ignored: 1000 / 7 with mid pulse -> q=%0d r=%0d busy=%0d", dif.result, dif.remainder, cyc);
    vectors++; if (dif.result !== 16'd142) begin miscompares++; $display("FAIL ignored_result got=%0d want=142", dif.result); end
    vectors++; if (dif.remainder !== 8'd6) begin miscompares++; $display("FAIL ignored_remainder got=%0d want=6", dif.remainder); end
    vectors++; if (cyc != FULL_BUSY) begin miscompares++; $display("FAIL ignored_busy_cycles got=%0d want=%0d", cyc, FULL_BUSY); end
  endtask

  task automatic test_reset_abort();
    int cyc;
    @(negedge clk);
    dif.start = 1'b1; dif.a_i = 16'd1000; dif.b_i = 8'd7;
    @(posedge clk);
    #1;
    dif.start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    vectors++; if (dif.busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy got=%b want=0", dif.busy); end
    vectors++; if (dif.result !== 16'h0 || dif.remainder !== 8'h0) begin miscompares++; $display("FAIL abort_outputs got=%h/%h want=0000/00", dif.result, dif.remainder); end
    vectors++; if (dif.sum_in_a !== 16'h0 || dif.sum_in_b !== 16'h0) begin miscompares++; $display("FAIL abort_adder got=%h/%h want=0000/0000", dif.sum_in_a, dif.sum_in_b); end
    $display("reset_abort: busy=%b result=%h remainder=%h", dif.busy, dif.result, dif.remainder);
    @(negedge clk);
    rst = 1'b1;
    run_div(16'd100, 8'd10, cyc);
    $display("after abort: 100 / 10 -> q=%0d r=%0d busy=%0d", dif.result, dif.remainder, cyc);
    vectors++; if (dif.result !== 16'd10) begin miscompares++; $display("FAIL post_abort_result got=%0d want=10", dif.result); end
    vectors++; if (dif.remainder !== 8'd0) begin miscompares++; $display("FAIL post_abort_remainder got=%0d want=0", dif.remainder); end
    vectors++; if (cyc != FULL_BUSY) begin miscompares++; $display("FAIL post_abort_busy got=%0d want=%0d", cyc, FULL_BUSY); end
  endtask

  task automatic test_random();
    int a, b, q, r, z, cyc, want_cyc;
    for (int n = 0; n < 40; n++) begin
      a = int'($urandom_range(0, 65535));
      if ($urandom_range(0, 7) == 0)      b = 0;
      else if ($urandom_range(0, 3) == 0) b = int'($urandom_range(1, 15));
      else                                b = int'($urandom_range(1, 255));
      model(a, b, q, r, z);
      want_cyc = (b == 0) ? ZERO_BUSY : FULL_BUSY;
      run_div(16'(a), 8'(b), cyc);
      $display("random %0d / %0d -> q=%0d r=%0d dbz=%b busy=%0d", a, b, dif.result, dif.remainder, dif.div_by_zero, cyc);
      vectors++; if (dif.result !== 16'(q)) begin miscompares++; $display("FAIL rnd_result %0d/%0d got=%0d want=%0d", a, b, dif.result, q); end
      vectors++; if (dif.remainder !== 8'(r)) begin miscompares++; $display("FAIL rnd_remainder %0d/%0d got=%0d want=%0d", a, b, dif.remainder, r); end
      vectors++; if (dif.div_by_zero !== 1'(z)) begin miscompares++; $display("FAIL rnd_dbz %0d/%0d got=%b want=%0d", a, b, dif.div_by_zero, z); end
      vectors++; if (cyc != want_cyc) begin miscompares++; $display("FAIL rnd_busy_cycles %0d/%0d got=%0d want=%0d", a, b, cyc, want_cyc); end
    end
  endtask

  initial begin
    dif.start = 1'b0;
    dif.a_i   = '0;
    dif.b_i   = '0;
    test_reset();
    test_directed();
    test_hold();
    test_start_ignored();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
